// File: rtl/reservation_station.sv
// Reservation station: holds ALU ops until both operands are ready, wakes them from the ALU/LSB CDBs
// and issues one op per cycle. Define RS_AGE_ISSUE_EN for oldest-first issue (default: lowest index).
module reservation_station #(
    parameter int RS_SIZE  = 16,
    parameter int TAG_W    = 5,
    parameter int OPENUM_W = 6,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic                ena_from_dsp,
    input  logic [OPENUM_W-1:0] openum_from_dsp,
    input  logic [DATA_W-1:0]   V1_from_dsp,
    input  logic [DATA_W-1:0]   V2_from_dsp,
    input  logic [TAG_W-1:0]    Q1_from_dsp,
    input  logic [TAG_W-1:0]    Q2_from_dsp,
    input  logic [DATA_W-1:0]   pc_from_dsp,
    input  logic [DATA_W-1:0]   imm_from_dsp,
    input  logic [TAG_W-1:0]    rob_id_from_dsp,
    output logic                full_to_if,
    input  logic                alu_cdb_valid,
    input  logic [TAG_W-1:0]    alu_cdb_tag,
    input  logic [DATA_W-1:0]   alu_cdb_data,
    input  logic                lsb_cdb_valid,
    input  logic [TAG_W-1:0]    lsb_cdb_tag,
    input  logic [DATA_W-1:0]   lsb_cdb_data,
    output logic                ena_to_alu,
    output logic [OPENUM_W-1:0] openum_to_alu,
    output logic [DATA_W-1:0]   V1_to_alu,
    output logic [DATA_W-1:0]   V2_to_alu,
    output logic [DATA_W-1:0]   pc_to_alu,
    output logic [DATA_W-1:0]   imm_to_alu,
    output logic [TAG_W-1:0]    rob_id_to_alu
);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0]  busy_q, busy_d;
    logic [OPENUM_W-1:0] op_q  [RS_SIZE];
    logic [OPENUM_W-1:0] op_d  [RS_SIZE];
    logic [DATA_W-1:0]   v1_q  [RS_SIZE];
    logic [DATA_W-1:0]   v1_d  [RS_SIZE];
    logic [DATA_W-1:0]   v2_q  [RS_SIZE];
    logic [DATA_W-1:0]   v2_d  [RS_SIZE];
    logic [DATA_W-1:0]   pc_q  [RS_SIZE];
    logic [DATA_W-1:0]   pc_d  [RS_SIZE];
    logic [DATA_W-1:0]   imm_q [RS_SIZE];
    logic [DATA_W-1:0]   imm_d [RS_SIZE];
    logic [TAG_W-1:0]    q1_q  [RS_SIZE];
    logic [TAG_W-1:0]    q1_d  [RS_SIZE];
    logic [TAG_W-1:0]    q2_q  [RS_SIZE];
    logic [TAG_W-1:0]    q2_d  [RS_SIZE];
    logic [TAG_W-1:0]    rob_q [RS_SIZE];
    logic [TAG_W-1:0]    rob_d [RS_SIZE];
`ifdef RS_AGE_ISSUE_EN
    logic [CNT_W-1:0]    age_q [RS_SIZE];
    logic [CNT_W-1:0]    age_d [RS_SIZE];
    logic [CNT_W-1:0]    sel_age;
`endif

    logic                ena_q, ena_d;
    logic [OPENUM_W-1:0] iss_op_q, iss_op_d;
    logic [DATA_W-1:0]   iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;
    logic [DATA_W-1:0]   iss_pc_q, iss_pc_d, iss_imm_q, iss_imm_d;
    logic [TAG_W-1:0]    iss_rob_q, iss_rob_d;

    logic [CNT_W-1:0]    free_cnt;
    logic                free_found, sel_found;
    logic [IDX_W-1:0]    free_idx, sel_idx;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        return (tag != '0) && ((alu_cdb_valid && alu_cdb_tag == tag) ||
                               (lsb_cdb_valid && lsb_cdb_tag == tag));
    endfunction

    function automatic logic [DATA_W-1:0] cdb_val(input logic [TAG_W-1:0] tag);
        return (alu_cdb_valid && alu_cdb_tag == tag) ? alu_cdb_data : lsb_cdb_data;
    endfunction

    // Free-slot search and issue pick both look only at registered state.
    always_comb begin
        free_cnt   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
`ifdef RS_AGE_ISSUE_EN
        sel_age    = '0;
`endif
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!busy_q[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end else if (q1_q[i] == '0 && q2_q[i] == '0) begin
`ifdef RS_AGE_ISSUE_EN
                if (!sel_found || age_q[i] > sel_age) begin
                    sel_age   = age_q[i];
`else
                if (!sel_found) begin
`endif
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign full_to_if = free_cnt < CNT_W'(2);

    always_comb begin
        busy_d    = busy_q;
        op_d      = op_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        pc_d      = pc_q;
        imm_d     = imm_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        rob_d     = rob_q;
`ifdef RS_AGE_ISSUE_EN
        age_d     = age_q;
`endif
        ena_d     = 1'b0;
        iss_op_d  = iss_op_q;
        iss_v1_d  = iss_v1_q;
        iss_v2_d  = iss_v2_q;
        iss_pc_d  = iss_pc_q;
        iss_imm_d = iss_imm_q;
        iss_rob_d = iss_rob_q;

        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && cdb_hit(q1_q[i])) begin
                v1_d[i] = cdb_val(q1_q[i]);
                q1_d[i] = '0;
            end
            if (busy_q[i] && cdb_hit(q2_q[i])) begin
                v2_d[i] = cdb_val(q2_q[i]);
                q2_d[i] = '0;
            end
`ifdef RS_AGE_ISSUE_EN
            if (busy_q[i] && age_q[i] != '1)
                age_d[i] = age_q[i] + CNT_W'(1);
`endif
        end

        if (sel_found) begin
            ena_d           = 1'b1;
            iss_op_d        = op_q[sel_idx];
            iss_v1_d        = v1_q[sel_idx];
            iss_v2_d        = v2_q[sel_idx];
            iss_pc_d        = pc_q[sel_idx];
            iss_imm_d       = imm_q[sel_idx];
            iss_rob_d       = rob_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
        end

        // Dispatch never targets the slot being issued: free_idx comes from busy_q.
        if (ena_from_dsp && !rollback && free_found) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = openum_from_dsp;
            pc_d[free_idx]   = pc_from_dsp;
            imm_d[free_idx]  = imm_from_dsp;
            rob_d[free_idx]  = rob_id_from_dsp;
            v1_d[free_idx]   = cdb_hit(Q1_from_dsp) ? cdb_val(Q1_from_dsp) : V1_from_dsp;
            q1_d[free_idx]   = cdb_hit(Q1_from_dsp) ? '0 : Q1_from_dsp;
            v2_d[free_idx]   = cdb_hit(Q2_from_dsp) ? cdb_val(Q2_from_dsp) : V2_from_dsp;
            q2_d[free_idx]   = cdb_hit(Q2_from_dsp) ? '0 : Q2_from_dsp;
`ifdef RS_AGE_ISSUE_EN
            age_d[free_idx]  = '0;
`endif
        end

        if (rollback) begin
            busy_d = '0;
            ena_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            ena_q     <= 1'b0;
            iss_op_q  <= '0;
            iss_v1_q  <= '0;
            iss_v2_q  <= '0;
            iss_pc_q  <= '0;
            iss_imm_q <= '0;
            iss_rob_q <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                op_q[i]  <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                pc_q[i]  <= '0;
                imm_q[i] <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                rob_q[i] <= '0;
`ifdef RS_AGE_ISSUE_EN
                age_q[i] <= '0;
`endif
            end
        end else if (rdy) begin
            busy_q    <= busy_d;
            op_q      <= op_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            pc_q      <= pc_d;
            imm_q     <= imm_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            rob_q     <= rob_d;
`ifdef RS_AGE_ISSUE_EN
            age_q     <= age_d;
`endif
            ena_q     <= ena_d;
            iss_op_q  <= iss_op_d;
            iss_v1_q  <= iss_v1_d;
            iss_v2_q  <= iss_v2_d;
            iss_pc_q  <= iss_pc_d;
            iss_imm_q <= iss_imm_d;
            iss_rob_q <= iss_rob_d;
        end
    end

    assign ena_to_alu    = ena_q;
    assign openum_to_alu = iss_op_q;
    assign V1_to_alu     = iss_v1_q;
    assign V2_to_alu     = iss_v2_q;
    assign pc_to_alu     = iss_pc_q;
    assign imm_to_alu    = iss_imm_q;
    assign rob_id_to_alu = iss_rob_q;
endmodule
